muldiv_unit: RTL and testbench

- Execute-stage M-extension unit, directly downstream of the control decoder.
- Consumes the 5-bit ALU control code for M-extension ops (10000..10111) plus the forwarded operands.
- Produces a registered 32-bit result with a start/busy/done handshake; the hazard unit stalls IF/ID/EX while busy.
- Multiply is single-cycle by default; divide/remainder is a 32-iteration restoring divider.

---
 rtl/muldiv_unit_pkg.sv | 39 +++
 rtl/muldiv_unit_div_core.sv | 66 ++++++
 rtl/muldiv_unit.sv | 206 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the M-extension multiply/divide unit: op codes,
// FSM state encodings and the RISC-V defined special-case divide results.
package muldiv_unit_pkg;

  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUOT      = 32'h8000_0000;
  localparam logic [31:0] OVF_REM       = 32'h0000_0000;
  localparam logic [31:0] SIGNED_MIN    = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL_RES = 3'd1,
    ST_DIV_RUN = 3'd2,
    ST_DIV_FIX = 3'd3
`ifdef MULDIV_ITER_MUL_EN
    ,
    ST_MUL_RUN = 3'd4
`endif
  } state_t;

  // Low two bits of a multiply op select operand signedness.
  function automatic logic mul_a_signed(input logic [1:0] sel);
    return sel != 2'b11;
  endfunction

  function automatic logic mul_b_signed(input logic [1:0] sel);
    return !sel[1];
  endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Restoring shift-subtract divider on unsigned magnitudes; one quotient bit
// per clock, 'last' is high during the final iteration cycle.
module muldiv_unit_div_core #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            last,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(ITERS);

  logic [CW-1:0]   count;
  logic            running;
  logic [XLEN-1:0] dsr;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  always_comb begin
    shifted = {remainder, quotient[XLEN-1]};
    diff    = shifted - {1'b0, dsr};
  end

  assign last = running && (count == CW'(ITERS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      running   <= 1'b0;
      dsr       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (abort) begin
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      quotient  <= dividend;
      remainder <= '0;
      dsr       <= divisor;
      count     <= '0;
      running   <= 1'b1;
    end else if (running) begin
      // A clear borrow bit means the trial subtraction fits: keep it.
      if (!diff[XLEN]) begin
        remainder <= diff[XLEN-1:0];
        quotient  <= {quotient[XLEN-2:0], 1'b1};
      end else begin
        remainder <= shifted[XLEN-1:0];
        quotient  <= {quotient[XLEN-2:0], 1'b0};
      end
      count <= count + 1'b1;
      if (last) begin
        running <= 1'b0;
        count   <= '0;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Execute-stage M-extension unit with start/busy/done handshake.
// Define MULDIV_ITER_MUL_EN for a 33-iteration shift-add multiplier.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [4:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  state_t          state;
  logic [4:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [4:0]      rd_q;
  logic            neg_q;
  logic            neg_r;

  logic            accept;
  logic            in_is_div;
  logic            in_div_signed;
  logic            in_fast;
  logic            div_start;
  logic [XLEN-1:0] mag_a_div;
  logic [XLEN-1:0] mag_b_div;

  logic            div_last;
  logic [XLEN-1:0] div_quot;
  logic [XLEN-1:0] div_rem;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] fast_res;
  logic [XLEN-1:0] mul_slice;
  logic [2*XLEN-1:0] mul_prod;

  assign busy = (state != ST_IDLE);

  assign accept        = (state == ST_IDLE) && start && alu_control[4] && !flush;
  assign in_is_div     = alu_control[2];
  assign in_div_signed = !alu_control[0];
  // Divide by zero and signed overflow skip the iterative divider entirely.
  assign in_fast       = in_is_div && ((op_b == '0) ||
                         (in_div_signed && (op_a == SIGNED_MIN) && (op_b == '1)));
  assign div_start     = accept && in_is_div && !in_fast;
  assign mag_a_div     = (in_div_signed && op_a[XLEN-1]) ? -op_a : op_a;
  assign mag_b_div     = (in_div_signed && op_b[XLEN-1]) ? -op_b : op_b;

  muldiv_unit_div_core #(
    .XLEN  (XLEN),
    .ITERS (DIV_ITERS)
  ) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (flush),
    .dividend  (mag_a_div),
    .divisor   (mag_b_div),
    .last      (div_last),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  assign q_fix = neg_q ? -div_quot : div_quot;
  assign r_fix = neg_r ? -div_rem  : div_rem;

  always_comb begin
    if (!op_q[1]) fast_res = (b_q == '0) ? DIV_ZERO_QUOT : OVF_QUOT;
    else          fast_res = (b_q == '0) ? a_q : OVF_REM;
  end

  assign mul_slice = (op_q == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

`ifdef MULDIV_ITER_MUL_EN
  localparam int MCW = $clog2(XLEN + 1);

  logic [2*XLEN-1:0] mc;
  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     mp;
  logic [MCW-1:0]    mul_cnt;
  logic [XLEN-1:0]   mag_a_mul;
  logic [XLEN-1:0]   mag_b_mul;
  logic              in_neg_p;
  logic              sa;
  logic              sb;

  assign sa        = mul_a_signed(alu_control[1:0]) && op_a[XLEN-1];
  assign sb        = mul_b_signed(alu_control[1:0]) && op_b[XLEN-1];
  assign mag_a_mul = sa ? -op_a : op_a;
  assign mag_b_mul = sb ? -op_b : op_b;
  assign in_neg_p  = sa ^ sb;
  assign mul_prod  = neg_q ? -acc : acc;
`else
  logic [XLEN:0]     ext_a;
  logic [XLEN:0]     ext_b;
  logic [2*XLEN-1:0] wide_a;
  logic [2*XLEN-1:0] wide_b;

  assign ext_a    = {mul_a_signed(op_q[1:0]) & a_q[XLEN-1], a_q};
  assign ext_b    = {mul_b_signed(op_q[1:0]) & b_q[XLEN-1], b_q};
  assign wide_a   = {{(XLEN-1){ext_a[XLEN]}}, ext_a};
  assign wide_b   = {{(XLEN-1){ext_b[XLEN]}}, ext_b};
  assign mul_prod = wide_a * wide_b;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rd_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`ifdef MULDIV_ITER_MUL_EN
      mc      <= '0;
      acc     <= '0;
      mp      <= '0;
      mul_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q <= alu_control;
            a_q  <= op_a;
            b_q  <= op_b;
            rd_q <= rd_in;
            if (in_is_div && !in_fast) begin
              neg_q <= in_div_signed && (op_a[XLEN-1] ^ op_b[XLEN-1]);
              neg_r <= in_div_signed && op_a[XLEN-1];
              state <= ST_DIV_RUN;
            end else if (in_is_div) begin
              state <= ST_MUL_RES;
            end else begin
`ifdef MULDIV_ITER_MUL_EN
              mc      <= {{XLEN{1'b0}}, mag_a_mul};
              mp      <= {1'b0, mag_b_mul};
              acc     <= '0;
              mul_cnt <= '0;
              neg_q   <= in_neg_p;
              state   <= ST_MUL_RUN;
`else
              state <= ST_MUL_RES;
`endif
            end
          end
        end
`ifdef MULDIV_ITER_MUL_EN
        ST_MUL_RUN: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            if (mp[0]) acc <= acc + mc;
            mc      <= mc << 1;
            mp      <= mp >> 1;
            mul_cnt <= mul_cnt + 1'b1;
            if (mul_cnt == MCW'(XLEN)) state <= ST_MUL_RES;
          end
        end
`endif
        ST_MUL_RES: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            result <= op_q[2] ? fast_res : mul_slice;
            rd_out <= rd_q;
            done   <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        ST_DIV_RUN: begin
          if (flush)         state <= ST_IDLE;
          else if (div_last) state <= ST_DIV_FIX;
        end
        ST_DIV_FIX: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            result <= op_q[1] ? r_fix : q_fix;
            rd_out <= rd_q;
            done   <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

`ifdef MULDIV_ITER_MUL_EN
  localparam int MUL_LAT = 35;
`else
  localparam int MUL_LAT = 2;
`endif
  localparam int DIV_LAT  = 34;
  localparam int FAST_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [4:0]  alu_control;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          at;
  } exp_t;

  exp_t sb[$];

  muldiv_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .flush       (flush),
    .alu_control (alu_control),
    .op_a        (op_a),
    .op_b        (op_b),
    .rd_in       (rd_in),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .rd_out      (rd_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got result %h rd %0d with nothing expected", result, rd_out);
        end else begin
          e = sb.pop_front();
          check_output("result", result, e.res);
          check_output("rd_out", 32'(rd_out), 32'(e.rd));
          check_output("done_cycle", 32'(cyc), 32'(e.at));
          check_output("busy_at_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic expect_done,
                                input logic [31:0] res, input int lat);
    @(negedge clk);
    start       = 1'b1;
    alu_control = op;
    op_a        = a;
    op_b        = b;
    rd_in       = rd;
    if (expect_done) sb.push_back('{res, rd, cyc + lat});
    @(negedge clk);
    start       = 1'b0;
    alu_control = OP_MULHU;
    op_a        = 32'hDEAD_BEEF;
    op_b        = 32'h0BAD_F00D;
    rd_in       = 5'h1F;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending busy %b expected 0 pending", sb.size(), busy);
      sb.delete();
    end
  endtask

  task automatic run_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res, input int lat);
    apply_stimulus(op, a, b, rd, 1'b1, res, lat);
    drain();
  endtask

  initial begin : watchdog
    #2_000_000;
    errors++;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : stimulus
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    alu_control = '0; op_a = '0; op_b = '0; rd_in = '0;
    repeat (3) @(negedge clk);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_result", result, 32'd0);
    check_output("reset_rd_out", 32'(rd_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // DIV flushed mid-run at t+10, then MUL 6x7 issued at t+12.
    apply_stimulus(OP_DIV, 32'hFFFF_FFEC, 32'd3, 5'd9, 1'b0, 32'd0, 0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_output("flush_busy", 32'(busy), 32'd0);
    apply_stimulus(OP_MUL, 32'd6, 32'd7, 5'd4, 1'b1, 32'd42, MUL_LAT);
    check_output("held_result", result, 32'd0);
    check_output("held_done", 32'(done), 32'd0);
    drain();

    // MUL 7 x -3 with busy profile.
    check_output("mul_busy_t", 32'(busy), 32'd0);
    apply_stimulus(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1, 32'hFFFF_FFEB, MUL_LAT);
    check_output("mul_busy_t1", 32'(busy), 32'd1);
    @(negedge clk);
    check_output("mul_busy_t2", 32'(busy), (MUL_LAT == 2) ? 32'd0 : 32'd1);
    drain();

    run_vec(OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, MUL_LAT);
    run_vec(OP_MULHSU, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'hC000_0000, MUL_LAT);
    run_vec(OP_MULHU,  32'h8000_0000, 32'h8000_0000, 5'd8,  32'h4000_0000, MUL_LAT);
    run_vec(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFE, MUL_LAT);
    run_vec(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'h0000_0000, MUL_LAT);
    run_vec(OP_DIV,    32'hFFFF_FFEC, 32'd3,         5'd12, 32'hFFFF_FFFA, DIV_LAT);
    run_vec(OP_REM,    32'hFFFF_FFEC, 32'd3,         5'd13, 32'hFFFF_FFFE, DIV_LAT);
    run_vec(OP_DIVU,   32'd100,       32'd7,         5'd14, 32'd14,        DIV_LAT);
    run_vec(OP_REMU,   32'd100,       32'd7,         5'd15, 32'd2,         DIV_LAT);
    run_vec(OP_DIV,    32'd20,        32'hFFFF_FFFD, 5'd16, 32'hFFFF_FFFA, DIV_LAT);
    run_vec(OP_REM,    32'd20,        32'hFFFF_FFFD, 5'd17, 32'd2,         DIV_LAT);
    run_vec(OP_DIV,    32'd42,        32'd0,         5'd18, 32'hFFFF_FFFF, FAST_LAT);
    run_vec(OP_REMU,   32'd42,        32'd0,         5'd19, 32'd42,        FAST_LAT);
    run_vec(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000, FAST_LAT);
    run_vec(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'd0,         FAST_LAT);
    run_vec(OP_MUL,    32'd6,         32'd7,         5'd22, 32'd42,        MUL_LAT);

    // Non-M op with start must be ignored.
    apply_stimulus(5'b00010, 32'd1, 32'd2, 5'd3, 1'b0, 32'd0, 0);
    check_output("non_m_busy", 32'(busy), 32'd0);

    // Reset at t+5 of a DIV.
    apply_stimulus(OP_DIV, 32'd1000, 32'd10, 5'd23, 1'b0, 32'd0, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_result", result, 32'd0);
    check_output("rst_rd_out", 32'(rd_out), 32'd0);

    // start together with flush in IDLE must not be accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    alu_control = OP_MUL; op_a = 32'd3; op_b = 32'd5; rd_in = 5'd24;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check_output("flush_start_busy", 32'(busy), 32'd0);

    repeat (40) @(negedge clk);
    check_output("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
